// File: rtl/cpu_pkg.sv
// Shared core types and the RV32I encoding constants used by the instruction encoder.
package cpu_pkg;

    typedef enum logic [2:0] {
        ALU_NOP = 3'd0,
        ALU_ADD = 3'd1,
        ALU_SUB = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4,
        ALU_XOR = 3'd5
    } alu_op_t;

    typedef enum logic [6:0] {
        OPCODE_OP     = 7'b0110011,
        OPCODE_OP_IMM = 7'b0010011
    } opcode_t;

    localparam logic [2:0]  FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0]  FUNCT3_XOR     = 3'b100;
    localparam logic [2:0]  FUNCT3_OR      = 3'b110;
    localparam logic [2:0]  FUNCT3_AND     = 3'b111;
    localparam logic [6:0]  FUNCT7_BASE    = 7'b0000000;
    localparam logic [6:0]  FUNCT7_SUB     = 7'b0100000;
    localparam logic [31:0] INSTR_NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        ENC_IDLE = 2'd0,
        ENC_HOLD = 2'd1,
        ENC_FULL = 2'd2
    } enc_state_t;

    function automatic logic [31:0] pack_r(input logic [6:0] funct7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] funct3,
                                           input logic [4:0] rd);
        return {funct7, rs2, rs1, funct3, rd, OPCODE_OP};
    endfunction

    function automatic logic [31:0] pack_i(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] funct3, input logic [4:0] rd);
        return {imm, rs1, funct3, rd, OPCODE_OP_IMM};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational mapping of one symbolic ALU request to its RV32I word, with illegal-request flag.
module instr_pack
    import cpu_pkg::*;
(
    input  alu_op_t     op,
    input  logic        use_imm,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [11:0] imm,
    output logic [31:0] instr,
    output logic        illegal
);

    logic [2:0] funct3_s;
    logic [6:0] funct7_s;

    // Field selection and illegal-request detection
    always_comb begin
        funct3_s = FUNCT3_ADD_SUB;
        funct7_s = FUNCT7_BASE;
        illegal  = 1'b0;
        case (op)
            ALU_ADD: funct3_s = FUNCT3_ADD_SUB;
            ALU_SUB: begin
                funct3_s = FUNCT3_ADD_SUB;
                funct7_s = FUNCT7_SUB;
                illegal  = use_imm;      // there is no SUBI in RV32I
            end
            ALU_AND: funct3_s = FUNCT3_AND;
            ALU_OR:  funct3_s = FUNCT3_OR;
            ALU_XOR: funct3_s = FUNCT3_XOR;
            default: illegal  = 1'b1;
        endcase
    end

    // Word assembly; illegal requests collapse to the canonical NOP
    always_comb begin
        if (illegal) begin
            instr = INSTR_NOP;
        end else if (use_imm) begin
            instr = pack_i(imm, rs1, funct3_s, rd);
        end else begin
            instr = pack_r(funct7_s, rs2, rs1, funct3_s, rd);
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I ALU-subset encoder: valid/ready requests in, machine words with
// sequential imem byte addresses out, stopping once the imem is full.
module instr_encoder
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  alu_op_t           in_op,
    input  logic              in_use_imm,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [11:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W+1:0] out_addr,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    enc_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              full_q, full_d;
    logic              err_q, err_d;

    logic [31:0] pack_instr_s;
    logic        pack_illegal_s;
    logic        last_s;
    logic        out_hs_s;
    logic        in_acc_s;

    instr_pack u_pack (
        .op      (in_op),
        .use_imm (in_use_imm),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .instr   (pack_instr_s),
        .illegal (pack_illegal_s)
    );

    // Handshake qualifiers; in_ready deliberately has no path from in_valid
    always_comb begin
        last_s   = (addr_q == ADDR_LAST);
        out_hs_s = valid_q && out_ready;
        in_ready = (state_q == ENC_IDLE) || ((state_q == ENC_HOLD) && out_ready && !last_s);
        in_acc_s = in_valid && in_ready;
    end

    // Next-state logic; clear overrides every handshake in the same cycle
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        valid_d = valid_q;
        full_d  = full_q;
        err_d   = err_q;
        if (clear) begin
            state_d = ENC_IDLE;
            addr_d  = {ADDR_W{1'b0}};
            instr_d = 32'h0000_0000;
            valid_d = 1'b0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ENC_IDLE: begin
                    if (in_acc_s) begin
                        state_d = ENC_HOLD;
                        instr_d = pack_instr_s;
                        valid_d = 1'b1;
                        err_d   = err_q | pack_illegal_s;
                    end else begin
                        state_d = ENC_IDLE;
                    end
                end
                ENC_HOLD: begin
                    if (out_hs_s && last_s) begin
                        // counter parks on the last word instead of wrapping
                        state_d = ENC_FULL;
                        valid_d = 1'b0;
                        full_d  = 1'b1;
                    end else if (out_hs_s) begin
                        addr_d = addr_q + ADDR_ONE;
                        if (in_acc_s) begin
                            state_d = ENC_HOLD;
                            instr_d = pack_instr_s;
                            valid_d = 1'b1;
                            err_d   = err_q | pack_illegal_s;
                        end else begin
                            state_d = ENC_IDLE;
                            valid_d = 1'b0;
                        end
                    end else begin
                        state_d = ENC_HOLD;
                    end
                end
                ENC_FULL: state_d = ENC_FULL;
                default: begin
                    state_d = ENC_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENC_IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            instr_q <= 32'h0000_0000;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_addr  = {addr_q, 2'b00};
    assign full      = full_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder, using a 4-word imem so fill is reachable.
module tb_instr_encoder;
    import cpu_pkg::*;

    localparam int unsigned ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    alu_op_t           in_op = ALU_ADD;
    logic              in_use_imm = 1'b0;
    logic [4:0]        in_rd = 5'd0;
    logic [4:0]        in_rs1 = 5'd0;
    logic [4:0]        in_rs2 = 5'd0;
    logic [11:0]       in_imm = 12'd0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [31:0]       out_instr;
    logic [ADDR_W+1:0] out_addr;
    logic              full;
    logic              err;

    int n_checks = 0;
    int n_pass   = 0;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_use_imm(in_use_imm),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic put(input alu_op_t op, input logic imm_sel, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
        in_op = op; in_use_imm = imm_sel; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
    endtask

    task automatic do_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out_instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", out_instr); else n_pass++;
        n_checks++; if (out_addr !== 4'd0) $display("FAIL rst_addr: got %0d want 0", out_addr); else n_pass++;
        n_checks++; if (full !== 1'b0 || err !== 1'b0) $display("FAIL rst_flags: got full=%b err=%b want 0 0", full, err); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_r_type();
        out_ready = 1'b1;
        @(negedge clk); put(ALU_ADD, 1'b0, 5'd3, 5'd1, 5'd2, 12'h000);
        @(negedge clk); in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL add_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_instr !== 32'h002081B3) $display("FAIL add_instr: got %h want 002081b3", out_instr); else n_pass++;
        n_checks++; if (out_addr !== 4'd0) $display("FAIL add_addr: got %0d want 0", out_addr); else n_pass++;
        @(negedge clk); put(ALU_SUB, 1'b0, 5'd5, 5'd6, 5'd7, 12'h000);
        @(negedge clk); in_valid = 1'b0;
        n_checks++; if (out_instr !== 32'h407302B3) $display("FAIL sub_instr: got %h want 407302b3", out_instr); else n_pass++;
        n_checks++; if (out_addr !== 4'd4) $display("FAIL sub_addr: got %0d want 4", out_addr); else n_pass++;
    endtask

    task automatic test_i_type();
        @(negedge clk); put(ALU_ADD, 1'b1, 5'd1, 5'd0, 5'd9, 12'hFFF);
        @(negedge clk); in_valid = 1'b0;
        n_checks++; if (out_instr !== 32'hFFF00093) $display("FAIL addi_instr: got %h want fff00093", out_instr); else n_pass++;
        n_checks++; if (out_addr !== 4'd8) $display("FAIL addi_addr: got %0d want 8", out_addr); else n_pass++;
        @(negedge clk); put(ALU_XOR, 1'b1, 5'd4, 5'd4, 5'd0, 12'h0F0);
        @(negedge clk); in_valid = 1'b0;
        n_checks++; if (out_instr !== 32'h0F024213) $display("FAIL xori_instr: got %h want 0f024213", out_instr); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL legal_err: got %b want 0", err); else n_pass++;
        do_clear();
    endtask

    task automatic test_illegal();
        @(negedge clk); put(ALU_SUB, 1'b1, 5'd2, 5'd3, 5'd4, 12'h001);
        n_checks++; if (err !== 1'b0) $display("FAIL pre_err: got %b want 0", err); else n_pass++;
        @(negedge clk); in_valid = 1'b0;
        n_checks++; if (out_instr !== 32'h00000013) $display("FAIL subi_instr: got %h want 00000013", out_instr); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL subi_err: got %b want 1", err); else n_pass++;
        @(negedge clk); put(ALU_NOP, 1'b0, 5'd7, 5'd8, 5'd9, 12'h000);
        @(negedge clk); in_valid = 1'b0;
        n_checks++; if (out_instr !== 32'h00000013 || out_addr !== 4'd4) $display("FAIL nop_word: got %h@%0d want 00000013@4", out_instr, out_addr); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL nop_err: got %b want 1", err); else n_pass++;
        do_clear();
        n_checks++; if (err !== 1'b0) $display("FAIL clr_err: got %b want 0", err); else n_pass++;
    endtask

    task automatic test_back_pressure();
        @(negedge clk); out_ready = 1'b0; put(ALU_AND, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) put(ALU_OR, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== 32'h003170B3 || out_addr !== 4'd0)
                $display("FAIL stall_%0d: got rdy=%b v=%b %h@%0d want 0 1 003170b3@0", c, in_ready, out_valid, out_instr, out_addr);
            else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", in_ready); else n_pass++;
        @(negedge clk); put(ALU_XOR, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000);
        n_checks++; if (out_instr !== 32'h003160B3 || out_addr !== 4'd4) $display("FAIL b2b_1: got %h@%0d want 003160b3@4", out_instr, out_addr); else n_pass++;
        @(negedge clk); in_valid = 1'b0;
        n_checks++; if (out_instr !== 32'h003140B3 || out_addr !== 4'd8) $display("FAIL b2b_2: got %h@%0d want 003140b3@8", out_instr, out_addr); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || out_addr !== 4'd12) $display("FAIL b2b_drain: got v=%b addr=%0d want 0 12", out_valid, out_addr); else n_pass++;
        do_clear();
    endtask

    task automatic test_fill();
        logic [3:0] seen[$];
        out_ready = 1'b1;
        @(negedge clk); put(ALU_NOP, 1'b0, 5'd0, 5'd0, 5'd0, 12'h000);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) seen.push_back(out_addr);
            put(ALU_ADD, 1'b0, 5'd3, 5'd1, 5'd2, 12'h000);
        end
        n_checks++; if (seen.size() != 4) $display("FAIL fill_count: got %0d want 4", seen.size()); else n_pass++;
        for (int i = 0; i < seen.size() && i < 4; i++) begin
            n_checks++; if (seen[i] !== 4'(4 * i)) $display("FAIL fill_addr_%0d: got %0d want %0d", i, seen[i], 4 * i); else n_pass++;
        end
        n_checks++; if (full !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL full_state: got full=%b rdy=%b v=%b want 1 0 0", full, in_ready, out_valid); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL fill_err: got %b want 1", err); else n_pass++;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        n_checks++; if (full !== 1'b0 || err !== 1'b0 || out_valid !== 1'b0 || out_addr !== 4'd0)
            $display("FAIL clear_state: got full=%b err=%b v=%b addr=%0d want 0 0 0 0", full, err, out_valid, out_addr);
        else n_pass++;
        @(negedge clk); in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_addr !== 4'd0 || out_instr !== 32'h002081B3)
            $display("FAIL post_clear: got v=%b %h@%0d want 1 002081b3@0", out_valid, out_instr, out_addr);
        else n_pass++;
        do_clear();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        @(negedge clk); put(ALU_ADD, 1'b0, 5'd3, 5'd1, 5'd2, 12'h000);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); out_ready = 1'b0; put(ALU_SUB, 1'b0, 5'd5, 5'd6, 5'd7, 12'h000);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_addr !== 4'd4) $display("FAIL hold_pre_rst: got v=%b addr=%0d want 1 4", out_valid, out_addr); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_addr !== 4'd0 || in_ready !== 1'b1)
            $display("FAIL async_rst: got v=%b addr=%0d rdy=%b want 0 0 1", out_valid, out_addr, in_ready);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_addr !== 4'd0 || out_instr !== 32'h407302B3)
            $display("FAIL after_rst: got v=%b %h@%0d want 1 407302b3@0", out_valid, out_instr, out_addr);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_i_type();
        test_illegal();
        test_back_pressure();
        test_fill();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
